// File: rtl/cb_if.sv
// Pattern-generator control/data bundle: the controller drives enable and
// num_levels, and the generator returns the packed cell-level word.
interface cb_if #(
  parameter int N_CELLS  = 12,
  parameter int LVL_BITS = 4
);
  logic                         enable;
  logic [LVL_BITS:0]            num_levels;
  logic [N_CELLS*LVL_BITS-1:0]  data_out;

  modport master (output enable, num_levels, input data_out);
  modport slave  (input enable, num_levels, output data_out);
endinterface

// File: rtl/cb_checkerboard.sv
// Multi-level diagonal checkerboard generator: cell i of each word is
// (i + step) mod L, and step advances by one on every enabled edge.

// One link of the modulo chain: next level = prev + 1, wrapping at L.
module cb_lane #(
  parameter int LVL_BITS = 4
) (
  input  logic [LVL_BITS-1:0] prev,
  input  logic [LVL_BITS:0]   lcnt,
  output logic [LVL_BITS-1:0] cur
);
  logic [LVL_BITS:0] inc;

  assign inc = {1'b0, prev} + (LVL_BITS+1)'(1);
  assign cur = (inc == lcnt) ? '0 : inc[LVL_BITS-1:0];
endmodule

module cb_checkerboard #(
  parameter int N_CELLS  = 12,
  parameter int LVL_BITS = 4
) (
  input  logic clk,
  input  logic rst,
  cb_if.slave  bus
);
  localparam logic [LVL_BITS:0] ONE  = (LVL_BITS+1)'(1);
  localparam logic [LVL_BITS:0] MAXL = (LVL_BITS+1)'(1 << LVL_BITS);

  logic [LVL_BITS-1:0]               step, step_eff, step_nxt;
  logic [LVL_BITS:0]                 lcnt, step_inc;
  logic [N_CELLS-1:0][LVL_BITS-1:0]  pat;
  logic [N_CELLS*LVL_BITS-1:0]       data_q;

  // Clamp the requested level count into 1..2**LVL_BITS.
  always_comb begin
    lcnt = bus.num_levels;
    if (bus.num_levels <= ONE)      lcnt = ONE;
    else if (bus.num_levels > MAXL) lcnt = MAXL;
  end

  // A step left over from a larger L restarts the pattern at phase 0.
  assign step_eff = ({1'b0, step} >= lcnt) ? '0 : step;
  assign step_inc = {1'b0, step_eff} + ONE;
  assign step_nxt = (step_inc == lcnt) ? '0 : step_inc[LVL_BITS-1:0];

  for (genvar i = 0; i < N_CELLS; i++) begin : g_cell
    logic [LVL_BITS-1:0] val;
    if (i == 0) begin : g_base
      assign val = step_eff;
    end else begin : g_inc
      cb_lane #(.LVL_BITS(LVL_BITS)) u_lane (
        .prev (g_cell[i-1].val),
        .lcnt (lcnt),
        .cur  (val)
      );
    end
    assign pat[i] = val;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      step   <= '0;
      data_q <= '0;
    end else if (bus.enable) begin
      step   <= step_nxt;
      data_q <= pat;
    end
  end

  assign bus.data_out = data_q;
endmodule

// File: tb/tb_cb_checkerboard.sv
// Directed checks of the checkerboard generator against hand-computed words.
module tb_cb_checkerboard;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;

  cb_if #(.N_CELLS(12), .LVL_BITS(4)) bus ();

  cb_checkerboard #(.N_CELLS(12), .LVL_BITS(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [47:0] got, input logic [47:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  // Advance one rising edge and settle before sampling.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    bus.enable = 1'b0;
    tick();
    rst = 1'b1;
  endtask

  logic [47:0] l4_seq [5] = '{48'h3210_3210_3210, 48'h0321_0321_0321,
                              48'h1032_1032_1032, 48'h2103_2103_2103,
                              48'h3210_3210_3210};

  initial begin
    bus.enable     = 1'b0;
    bus.num_levels = 5'd4;

    // reset state
    rst = 1'b0;
    tick();
    chk("reset", bus.data_out, 48'h0);
    rst = 1'b1;

    // L=4 running sequence with wrap on edge 5
    bus.enable = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk($sformatf("l4_edge%0d", i + 1), bus.data_out, l4_seq[i]);
    end

    // L=16 single pulse, then hold, then one more step
    do_reset();
    bus.num_levels = 5'd16;
    bus.enable = 1'b1;
    tick();
    chk("l16_pulse", bus.data_out, 48'hBA98_7654_3210);
    bus.enable = 1'b0;
    tick();
    chk("l16_hold1", bus.data_out, 48'hBA98_7654_3210);
    tick();
    chk("l16_hold2", bus.data_out, 48'hBA98_7654_3210);
    bus.enable = 1'b1;
    tick();
    chk("l16_step1", bus.data_out, 48'hCBA9_8765_4321);

    // L=1 and num_levels=0: all zeros, step pinned at 0
    do_reset();
    bus.num_levels = 5'd1;
    bus.enable = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("l1_edge%0d", i + 1), bus.data_out, 48'h0);
    end
    bus.num_levels = 5'd0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("l0_edge%0d", i + 1), bus.data_out, 48'h0);
    end
    bus.num_levels = 5'd16;
    tick();
    chk("l1_step_zero", bus.data_out, 48'hBA98_7654_3210);

    // L=3 for two edges, then shrink to L=2 with stale step 2
    do_reset();
    bus.num_levels = 5'd3;
    bus.enable = 1'b1;
    tick();
    chk("l3_edge1", bus.data_out, 48'h2102_1021_0210);
    tick();
    chk("l3_edge2", bus.data_out, 48'h0210_2102_1021);
    bus.num_levels = 5'd2;
    tick();
    chk("l2_restart", bus.data_out, 48'h1010_1010_1010);
    tick();
    chk("l2_step1", bus.data_out, 48'h0101_0101_0101);

    // reset mid-sequence with enable still high
    do_reset();
    bus.num_levels = 5'd4;
    bus.enable = 1'b1;
    tick();
    tick();
    chk("mid_pre", bus.data_out, 48'h0321_0321_0321);
    rst = 1'b0;
    tick();
    chk("mid_reset", bus.data_out, 48'h0);
    rst = 1'b1;
    tick();
    chk("mid_after", bus.data_out, 48'h3210_3210_3210);

    // num_levels above 16 clamps to 16
    do_reset();
    bus.num_levels = 5'd20;
    bus.enable = 1'b1;
    tick();
    chk("l20_edge1", bus.data_out, 48'hBA98_7654_3210);
    for (int i = 0; i < 4; i++) tick();
    chk("l20_edge5", bus.data_out, 48'hFEDC_BA98_7654);
    tick();
    chk("l20_wrap", bus.data_out, 48'h0FED_CBA9_8765);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
